// File: rtl/wordcell_array_ctrl.sv
// Round-robin two-port controller for a bank of NAND-latch word cells.
// Every access runs SETUP / STROBE / HOLD so selects never overlap a bus change.
module wordcell_array_ctrl #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2,
  parameter int WIDTH      = 8,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              err,
  output logic              busy,
  output logic              cell_op,
  output logic [DEPTH-1:0]  cell_sel,
  output logic [WIDTH-1:0]  cell_in,
  input  logic [WIDTH-1:0]  cell_out
);

  // Requester handshake: req plus command stay stable from assertion until the
  // single-cycle ack; the command is latched at grant and only the latch is used.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } state_e;

  localparam logic [1:0] CNT_LAST = 2'(STROBE_CYC - 1);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;      // 0 = A, 1 = B
  logic                cmd_port_q, cmd_port_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic                cmd_oor_q, cmd_oor_d;
  logic [WIDTH-1:0]    rd_q, rd_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                cell_op_q, cell_op_d;
  logic [DEPTH-1:0]    cell_sel_q, cell_sel_d;
  logic [WIDTH-1:0]    cell_in_q, cell_in_d;
  logic [WIDTH-1:0]    rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0]    rdata_b_q, rdata_b_d;

  logic                grant_a, grant_b;
  logic                nxt_we;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [WIDTH-1:0]    nxt_wdata;
  logic                nxt_oor;
  logic [DEPTH-1:0]    sel_vec;

  // On contention the port that was not granted last wins.
  assign grant_a   = req_a && (!req_b || last_q);
  assign grant_b   = req_b && (!req_a || !last_q);
  assign nxt_we    = grant_b ? we_b    : we_a;
  assign nxt_addr  = grant_b ? addr_b  : addr_a;
  assign nxt_wdata = grant_b ? wdata_b : wdata_a;
  assign nxt_oor   = int'({1'b0, nxt_addr}) >= DEPTH;

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_vec[i] = !cmd_oor_q && (int'({1'b0, cmd_addr_q}) == i);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    cmd_port_d = cmd_port_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_oor_d  = cmd_oor_q;
    rd_d       = rd_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    cell_op_d  = cell_op_q;
    cell_sel_d = cell_sel_q;
    cell_in_d  = cell_in_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          cmd_port_d = grant_b;
          last_d     = grant_b;
          cmd_we_d   = nxt_we;
          cmd_addr_d = nxt_addr;
          cmd_oor_d  = nxt_oor;
          cell_op_d  = nxt_we;
          cell_in_d  = nxt_we ? nxt_wdata : '0;
          cell_sel_d = '0;
          busy_d     = 1'b1;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cell_sel_d = sel_vec;
        cnt_d      = 2'd0;
        state_d    = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          cell_sel_d = '0;
          if (!cmd_we_q) begin
            rd_d = cmd_oor_q ? '0 : cell_out;
          end
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_HOLD: begin
        ack_a_d = !cmd_port_q;
        ack_b_d = cmd_port_q;
        err_d   = cmd_oor_q;
        if (!cmd_we_q) begin
          if (cmd_port_q) rdata_b_d = rd_q;
          else            rdata_a_d = rd_q;
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      last_q     <= 1'b1;
      cmd_port_q <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_oor_q  <= 1'b0;
      rd_q       <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cell_op_q  <= 1'b0;
      cell_sel_q <= '0;
      cell_in_q  <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      cmd_port_q <= cmd_port_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_oor_q  <= cmd_oor_d;
      rd_q       <= rd_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cell_op_q  <= cell_op_d;
      cell_sel_q <= cell_sel_d;
      cell_in_q  <= cell_in_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign cell_op  = cell_op_q;
  assign cell_sel = cell_sel_q;
  assign cell_in  = cell_in_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// Bench for wordcell_array_ctrl: directed tests on a DEPTH=6/STROBE_CYC=1 instance
// and a protocol-checked random run on a DEPTH=4/STROBE_CYC=3 instance.
module tb_wordcell_array_ctrl;

  localparam int W   = 8;
  localparam int D1  = 6;
  localparam int A1  = 3;
  localparam int SC1 = 1;
  localparam int D2  = 4;
  localparam int A2  = 2;
  localparam int SC2 = 3;
  localparam int EW  = 3 + A1 + W;
  localparam int EW2 = 2 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance 1 ----------------
  logic          req_a, req_b, we_a, we_b;
  logic [A1-1:0] addr_a, addr_b;
  logic [W-1:0]  wdata_a, wdata_b, rdata_a, rdata_b, cell_in, cell_out;
  logic          ack_a, ack_b, err, busy, cell_op;
  logic [D1-1:0] cell_sel;

  wordcell_array_ctrl #(.DEPTH(D1), .ADDR_W(A1), .WIDTH(W), .STROBE_CYC(SC1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .err(err), .busy(busy), .cell_op(cell_op), .cell_sel(cell_sel),
    .cell_in(cell_in), .cell_out(cell_out)
  );

  logic [W-1:0] mem1 [D1];
  always_comb begin
    cell_out = '0;
    for (int i = 0; i < D1; i++)
      if (cell_sel[i] && !cell_op) cell_out = cell_out | mem1[i];
  end
  always @(posedge clk)
    for (int i = 0; i < D1; i++)
      if (cell_sel[i] && cell_op) mem1[i] <= cell_in;

  // ---------------- instance 2 ----------------
  logic          req_a2, req_b2, we_a2, we_b2;
  logic [A2-1:0] addr_a2, addr_b2;
  logic [W-1:0]  wdata_a2, wdata_b2, rdata_a2, rdata_b2, cell_in2, cell_out2;
  logic          ack_a2, ack_b2, err2, busy2, cell_op2;
  logic [D2-1:0] cell_sel2;

  wordcell_array_ctrl #(.DEPTH(D2), .ADDR_W(A2), .WIDTH(W), .STROBE_CYC(SC2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a2), .req_b(req_b2), .we_a(we_a2), .we_b(we_b2),
    .addr_a(addr_a2), .addr_b(addr_b2), .wdata_a(wdata_a2), .wdata_b(wdata_b2),
    .ack_a(ack_a2), .ack_b(ack_b2), .rdata_a(rdata_a2), .rdata_b(rdata_b2),
    .err(err2), .busy(busy2), .cell_op(cell_op2), .cell_sel(cell_sel2),
    .cell_in(cell_in2), .cell_out(cell_out2)
  );

  logic [W-1:0] mem2 [D2];
  always_comb begin
    cell_out2 = '0;
    for (int i = 0; i < D2; i++)
      if (cell_sel2[i] && !cell_op2) cell_out2 = cell_out2 | mem2[i];
  end
  always @(posedge clk)
    for (int i = 0; i < D2; i++)
      if (cell_sel2[i] && cell_op2) mem2[i] <= cell_in2;

  // ---------------- scoreboards ----------------
  // entry = {port, we, err, addr, data}
  logic [EW-1:0]  exp_q[$];
  // entry = {port, we, data}
  logic [EW2-1:0] exp2_q[$];

  task automatic push_exp(input bit port, input bit we, input bit e, input logic [A1-1:0] addr,
                          input logic [W-1:0] data);
    exp_q.push_back({port, we, e, addr, data});
  endtask

  logic [D1-1:0] sel_seen;
  int            sel_cyc;
  logic [W-1:0]  mdl_rd_a, mdl_rd_b, prev_in;
  logic          prev_op, prev_ack_a, prev_ack_b;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [D1-1:0] exp_sel;
    if (!rst_n) begin
      sel_seen = '0; sel_cyc = 0; mdl_rd_a = '0; mdl_rd_b = '0;
      prev_in = '0; prev_op = 1'b0; prev_ack_a = 1'b0; prev_ack_b = 1'b0;
    end else begin
      if (cell_sel != '0) begin
        sel_cyc++;
        sel_seen = sel_seen | cell_sel;
      end
      check("sel_onehot", 32'($countones(cell_sel) > 1), 0);
      check("sel_during_change", 32'((cell_sel != '0) && ((cell_in !== prev_in) || (cell_op !== prev_op))), 0);
      check("ack_width", 32'((ack_a && prev_ack_a) || (ack_b && prev_ack_b)), 0);
      check("err_without_ack", 32'(err && !(ack_a || ack_b)), 0);
      if (ack_a || ack_b) begin
        check("ack_both", 32'(ack_a && ack_b), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          exp_sel = e[EW-3] ? '0 : (D1'(1) << e[W+A1-1:W]);
          check("ack_port", 32'(ack_b), 32'(e[EW-1]));
          check("err", 32'(err), 32'(e[EW-3]));
          check("sel_bits", 32'(sel_seen), 32'(exp_sel));
          check("sel_cycles", 32'(sel_cyc), e[EW-3] ? 0 : SC1);
          if (!e[EW-2]) begin
            if (e[EW-1]) mdl_rd_b = e[W-1:0];
            else         mdl_rd_a = e[W-1:0];
          end
          check("rdata_a", 32'(rdata_a), 32'(mdl_rd_a));
          check("rdata_b", 32'(rdata_b), 32'(mdl_rd_b));
        end
        sel_seen = '0;
        sel_cyc  = 0;
      end
      prev_in = cell_in; prev_op = cell_op; prev_ack_a = ack_a; prev_ack_b = ack_b;
    end
  end

  logic [W-1:0] prev_in2;
  logic         prev_op2, prev_ack2;
  int           sel_cyc2;

  always @(negedge clk) begin
    logic [EW2-1:0] e;
    if (!rst_n) begin
      prev_in2 = '0; prev_op2 = 1'b0; prev_ack2 = 1'b0; sel_cyc2 = 0;
    end else begin
      if (cell_sel2 != '0) sel_cyc2++;
      check("p2_sel_onehot", 32'($countones(cell_sel2) > 1), 0);
      check("p2_sel_during_change", 32'((cell_sel2 != '0) && ((cell_in2 !== prev_in2) || (cell_op2 !== prev_op2))), 0);
      check("p2_ack_width", 32'((ack_a2 || ack_b2) && prev_ack2), 0);
      if (ack_a2 || ack_b2) begin
        if (exp2_q.size() == 0) begin
          check("p2_unexpected_ack", 1, 0);
        end else begin
          e = exp2_q.pop_front();
          check("p2_ack_port", 32'(ack_b2), 32'(e[EW2-1]));
          check("p2_sel_cycles", 32'(sel_cyc2), SC2);
          check("p2_err", 32'(err2), 0);
          if (!e[EW2-2])
            check("p2_rdata", 32'(e[EW2-1] ? rdata_b2 : rdata_a2), 32'(e[W-1:0]));
        end
        sel_cyc2 = 0;
      end
      prev_in2 = cell_in2; prev_op2 = cell_op2; prev_ack2 = ack_a2 || ack_b2;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_req(input bit port, input bit val, input bit we, input logic [A1-1:0] addr,
                           input logic [W-1:0] data);
    if (port) begin req_b = val; we_b = we; addr_b = addr; wdata_b = data; end
    else      begin req_a = val; we_a = we; addr_a = addr; wdata_a = data; end
  endtask

  // Called #1 after a posedge with the DUT idle or arbitrating; exp_lat 0 skips latency check.
  task automatic access(input bit port, input bit we, input logic [A1-1:0] addr,
                        input logic [W-1:0] data, input int exp_lat);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    drive_req(port, 1'b1, we, addr, data);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (port ? ack_b : ack_a) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_timeout", 32'(got), 1);
    if (got && exp_lat > 0) check("ack_latency", cyc, exp_lat);
    drive_req(port, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] exp_mem2 [D2];

  task automatic access2(input bit port, input bit we, input logic [A2-1:0] addr, input logic [W-1:0] data);
    int cyc;
    bit got;
    exp2_q.push_back({port, we, we ? data : exp_mem2[addr]});
    if (we) exp_mem2[addr] = data;
    if (port) begin req_b2 = 1'b1; we_b2 = we; addr_b2 = addr; wdata_b2 = data; end
    else      begin req_a2 = 1'b1; we_a2 = we; addr_a2 = addr; wdata_a2 = data; end
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (port ? ack_b2 : ack_a2) begin
        got = 1'b1;
        break;
      end
    end
    check("p2_ack_timeout", 32'(got), 1);
    if (got) check("p2_ack_latency", cyc, 3 + SC2);
    req_a2 = 1'b0; req_b2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'({ack_a, ack_b}), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_sel"},   32'(cell_sel), 0);
    check({tag, "_op"},    32'(cell_op), 0);
    check({tag, "_in"},    32'(cell_in), 0);
    check({tag, "_rdata"}, 32'({rdata_a, rdata_b}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lowc, gap;
    bit got;
    logic [W-1:0] bb_data [4];
    bb_data[0] = 8'h5A; bb_data[1] = 8'h00; bb_data[2] = 8'hA5; bb_data[3] = 8'h00;
    rst_n = 1'b0;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    req_a2 = 0; req_b2 = 0; we_a2 = 0; we_b2 = 0; addr_a2 = '0; addr_b2 = '0; wdata_a2 = '0; wdata_b2 = '0;
    for (int i = 0; i < D2; i++) exp_mem2[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset2_outputs", 32'({ack_a2, ack_b2, err2, busy2, cell_sel2, cell_op2}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read on port A
    push_exp(0, 1, 0, 3'd2, 8'h55);
    access(0, 1, 3'd2, 8'h55, 4);
    push_exp(0, 0, 0, 3'd2, 8'h55);
    access(0, 0, 3'd2, 8'h00, 4);

    // simultaneous requests alternate A, B, A, B
    do_reset();
    push_exp(0, 1, 0, 3'd1, 8'hCC);
    push_exp(1, 1, 0, 3'd3, 8'h33);
    push_exp(0, 0, 0, 3'd1, 8'hCC);
    push_exp(1, 0, 0, 3'd3, 8'h33);
    fork
      begin access(0, 1, 3'd1, 8'hCC, 0); access(0, 0, 3'd1, 8'h00, 0); end
      begin access(1, 1, 3'd3, 8'h33, 0); access(1, 0, 3'd3, 8'h00, 0); end
    join
    check("cell1_value", 32'(mem1[1]), 32'h CC);
    check("cell3_value", 32'(mem1[3]), 32'h33);

    // out-of-range accesses
    push_exp(1, 0, 1, 3'd7, 8'h00);
    access(1, 0, 3'd7, 8'h00, 4);
    push_exp(0, 1, 1, 3'd6, 8'hAA);
    access(0, 1, 3'd6, 8'hAA, 4);

    // reset in the middle of STROBE of an A write
    drive_req(0, 1'b1, 1'b1, 3'd0, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("strobe_sel", 32'(cell_sel), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    drive_req(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_no_ack", 32'({ack_a, ack_b}), 0);
    push_exp(0, 1, 0, 3'd0, 8'hFF);
    push_exp(1, 0, 0, 3'd3, 8'h33);
    fork
      access(0, 1, 3'd0, 8'hFF, 4);
      access(1, 0, 3'd3, 8'h00, 0);
    join
    check("cell0_value", 32'(mem1[0]), 32'hFF);

    // back-to-back: A keeps req high across ack
    push_exp(0, 1, 0, 3'd4, 8'h5A);
    push_exp(0, 0, 0, 3'd4, 8'h5A);
    push_exp(0, 1, 0, 3'd5, 8'hA5);
    push_exp(0, 0, 0, 3'd5, 8'hA5);
    drive_req(0, 1'b1, 1'b1, 3'd4, bb_data[0]);
    lowc = 0;
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        gap++;
        if (!busy) lowc++;
        if (ack_a) begin
          got = 1'b1;
          break;
        end
      end
      check("b2b_ack_timeout", 32'(got), 1);
      if (k > 0) begin
        check("b2b_busy_low", lowc, 1);
        check("b2b_period", gap, SC1 + 4);
      end
      lowc = 0;
      gap = 0;
      if (k < 3) drive_req(0, 1'b1, (k % 2) == 1, (k >= 1) ? 3'd5 : 3'd4, bb_data[k+1]);
    end
    drive_req(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // random run on the long-strobe instance
    for (int i = 0; i < D2; i++) access2(1'($urandom_range(0, 1)), 1'b1, A2'(i), W'($urandom_range(0, 255)));
    for (int i = 0; i < 196; i++)
      access2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), A2'($urandom_range(0, D2 - 1)),
              W'($urandom_range(0, 255)));

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 0);
    check("queue2_drain", 32'(exp2_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
